// File: rtl/swc_cell_packer.sv
// -----------------------------------------------------------------------------
// swc_cell_packer
//
// Ingress cell packer placed directly in front of the switch core. It takes one
// frame at a time as a byte stream and packs the bytes into 128-bit words,
// which it writes into the core's cell data FIFO. After the last word of each
// frame it writes one 16-bit descriptor into the core's pointer FIFO. Core
// backpressure is honoured only between frames.
//
// Parameters:
//   MAX_WORDS            maximum 128-bit words stored per frame (1..255)
//
// Ports:
//   clk, rstn              clock; asynchronous active-low reset
//   in_valid/in_ready      byte handshake
//   in_data                frame byte
//   in_sof / in_eof        first / last byte of frame (may coincide)
//   in_portmap             destination port map, sampled on the accepted sof
//   i_cell_bp              core backpressure (registered inside the core)
//   i_cell_data_fifo_din   packed word, byte k in bits [127-8k -: 8]
//   i_cell_data_fifo_wr    data FIFO write strobe
//   i_cell_ptr_fifo_din    descriptor {4'b0, portmap, word_cnt}
//   i_cell_ptr_fifo_wr     pointer FIFO write strobe
//   stat_frames/drops/trunc  wrapping frame statistics
//
// Build option:
//   SWC_CELL_PACKER_STATS_EN  when defined, the three statistics counters are
//                             built; otherwise the stat outputs are tied to 0.
// -----------------------------------------------------------------------------
module swc_cell_packer #(
    parameter int MAX_WORDS = 96
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_sof,
    input  logic         in_eof,
    input  logic [3:0]   in_portmap,
    input  logic         i_cell_bp,
    output logic [127:0] i_cell_data_fifo_din,
    output logic         i_cell_data_fifo_wr,
    output logic [15:0]  i_cell_ptr_fifo_din,
    output logic         i_cell_ptr_fifo_wr,
    output logic [15:0]  stat_frames,
    output logic [15:0]  stat_drops,
    output logic [15:0]  stat_trunc
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PACK,
        S_TRUNC,
        S_DROP,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_run;        // low during reset and the first cycle after
    logic           r_hold;       // second HOLD cycle marker
    logic [127:0]   r_word;
    logic [3:0]     r_byte_cnt;
    logic [7:0]     r_word_cnt;
    logic [3:0]     r_portmap;
    logic [127:0]   r_data_din;
    logic           r_data_wr;
    logic [15:0]    r_ptr_din;
    logic           r_ptr_wr;

    logic           w_in_ready;
    logic           w_acc;
    logic           w_frame_start;
    logic           w_lane_wr;
    logic           w_emit_word;
    logic           w_emit_ptr;
    logic [7:0]     w_cnt_inc;
    logic [7:0]     w_ptr_cnt;
    logic [3:0]     w_ptr_pm;
    logic [3:0]     w_byte_idx;
    logic [127:0]   w_word_fill;

    // Backpressure only gates the start of a frame; once inside, every byte is
    // taken so the frame is never split across a bp window.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_run) begin
            unique case (r_state)
                S_IDLE:  w_in_ready = !i_cell_bp;
                S_PACK,
                S_TRUNC,
                S_DROP:  w_in_ready = 1'b1;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign w_acc     = in_valid && w_in_ready;
    assign w_cnt_inc = r_word_cnt + 8'd1;

    // Next-state and strobe decode
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_lane_wr     = 1'b0;
        w_emit_word   = 1'b0;
        w_emit_ptr    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && in_sof) begin
                    if (in_portmap == 4'd0) begin
                        if (!in_eof) w_state_next = S_DROP;
                    end else begin
                        w_frame_start = 1'b1;
                        w_lane_wr     = 1'b1;
                        if (in_eof) begin
                            w_emit_word  = 1'b1;
                            w_emit_ptr   = 1'b1;
                            w_state_next = S_HOLD;
                        end else begin
                            w_state_next = S_PACK;
                        end
                    end
                end
            end
            S_PACK: begin
                if (w_acc) begin
                    w_lane_wr = 1'b1;
                    if (in_eof) begin
                        w_emit_word  = 1'b1;
                        w_emit_ptr   = 1'b1;
                        w_state_next = S_HOLD;
                    end else if (r_byte_cnt == 4'hF) begin
                        w_emit_word = 1'b1;
                        if (w_cnt_inc == MAX_CNT) w_state_next = S_TRUNC;
                    end
                end
            end
            S_TRUNC: begin
                if (w_acc && in_eof) begin
                    w_emit_ptr   = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_DROP: begin
                if (w_acc && in_eof) w_state_next = S_IDLE;
            end
            S_HOLD: begin
                if (r_hold) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lane merge: a new frame starts from an all-zero word at lane 0
    always_comb begin
        w_byte_idx  = w_frame_start ? 4'd0 : r_byte_cnt;
        w_word_fill = w_frame_start ? 128'd0 : r_word;
        for (int k = 0; k < 16; k++) begin
            if (w_byte_idx == 4'(k)) w_word_fill[127-8*k -: 8] = in_data;
        end
    end

    // In TRUNC no word is emitted, so the held count (MAX_WORDS) is reported
    assign w_ptr_cnt = w_frame_start ? 8'd1 : (w_emit_word ? w_cnt_inc : r_word_cnt);
    assign w_ptr_pm  = w_frame_start ? in_portmap : r_portmap;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_run      <= 1'b0;
            r_hold     <= 1'b0;
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_portmap  <= '0;
            r_data_din <= '0;
            r_data_wr  <= 1'b0;
            r_ptr_din  <= '0;
            r_ptr_wr   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run     <= 1'b1;
            r_hold    <= (r_state == S_HOLD) && !r_hold;
            r_data_wr <= w_emit_word;
            r_ptr_wr  <= w_emit_ptr;
            if (w_emit_word) r_data_din <= w_word_fill;
            if (w_emit_ptr)  r_ptr_din  <= {4'b0, w_ptr_pm, w_ptr_cnt};
            if (w_frame_start) r_portmap <= in_portmap;
            if (w_lane_wr) begin
                if (w_emit_word) begin
                    r_word     <= '0;
                    r_byte_cnt <= '0;
                end else begin
                    r_word     <= w_word_fill;
                    r_byte_cnt <= w_byte_idx + 4'd1;
                end
            end
            if (w_frame_start)    r_word_cnt <= w_emit_word ? 8'd1 : 8'd0;
            else if (w_emit_word) r_word_cnt <= w_cnt_inc;
        end
    end

    assign i_cell_data_fifo_din = r_data_din;
    assign i_cell_data_fifo_wr  = r_data_wr;
    assign i_cell_ptr_fifo_din  = r_ptr_din;
    assign i_cell_ptr_fifo_wr   = r_ptr_wr;

`ifdef SWC_CELL_PACKER_STATS_EN
    logic        w_drop;
    logic        w_trunc;
    logic [15:0] r_stat_frames;
    logic [15:0] r_stat_drops;
    logic [15:0] r_stat_trunc;

    assign w_drop  = (r_state == S_IDLE) && w_acc && in_sof && (in_portmap == 4'd0);
    assign w_trunc = (r_state == S_TRUNC) && w_emit_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_frames <= '0;
            r_stat_drops  <= '0;
            r_stat_trunc  <= '0;
        end else begin
            if (w_emit_ptr) r_stat_frames <= r_stat_frames + 16'd1;
            if (w_drop)     r_stat_drops  <= r_stat_drops + 16'd1;
            if (w_trunc)    r_stat_trunc  <= r_stat_trunc + 16'd1;
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_drops  = r_stat_drops;
    assign stat_trunc  = r_stat_trunc;
`else
    assign stat_frames = 16'd0;
    assign stat_drops  = 16'd0;
    assign stat_trunc  = 16'd0;
`endif

endmodule

// File: tb/tb_swc_cell_packer.sv
// -----------------------------------------------------------------------------
// tb_swc_cell_packer
//
// Directed bench for swc_cell_packer: a table of frames with hand-computed
// words and descriptors, plus hand-written sequences for back-to-back frames,
// truncation, backpressure and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_swc_cell_packer;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_sof;
    logic         in_eof;
    logic [3:0]   in_portmap;
    logic         i_cell_bp;
    logic [127:0] i_cell_data_fifo_din;
    logic         i_cell_data_fifo_wr;
    logic [15:0]  i_cell_ptr_fifo_din;
    logic         i_cell_ptr_fifo_wr;
    logic [15:0]  stat_frames;
    logic [15:0]  stat_drops;
    logic [15:0]  stat_trunc;

    swc_cell_packer #(.MAX_WORDS(96)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_data              (in_data),
        .in_sof               (in_sof),
        .in_eof               (in_eof),
        .in_portmap           (in_portmap),
        .i_cell_bp            (i_cell_bp),
        .i_cell_data_fifo_din (i_cell_data_fifo_din),
        .i_cell_data_fifo_wr  (i_cell_data_fifo_wr),
        .i_cell_ptr_fifo_din  (i_cell_ptr_fifo_din),
        .i_cell_ptr_fifo_wr   (i_cell_ptr_fifo_wr),
        .stat_frames          (stat_frames),
        .stat_drops           (stat_drops),
        .stat_trunc           (stat_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write capture, sampled on the falling edge
    int           d_cyc[$];
    logic [127:0] d_val[$];
    int           p_cyc[$];
    logic [15:0]  p_val[$];

    always @(negedge clk) begin
        if (i_cell_data_fifo_wr) begin
            d_cyc.push_back(cyc);
            d_val.push_back(i_cell_data_fifo_din);
        end
        if (i_cell_ptr_fifo_wr) begin
            p_cyc.push_back(cyc);
            p_val.push_back(i_cell_ptr_fifo_din);
        end
    end

    int checks = 0;
    int errors = 0;
    int acc_c[0:2047];
    int exp_frames = 0;
    int exp_drops  = 0;
    int exp_trunc  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sx(input int v);
`ifdef SWC_CELL_PACKER_STATS_EN
        return 16'(v);
`else
        return (v == v) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic clear_q();
        d_cyc.delete(); d_val.delete(); p_cyc.delete(); p_val.delete();
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_stat_frames"}, stat_frames, sx(exp_frames));
        chk({nm, "_stat_drops"},  stat_drops,  sx(exp_drops));
        chk({nm, "_stat_trunc"},  stat_trunc,  sx(exp_trunc));
    endtask

    // Drive len bytes (byte i = base + i); records the acceptance cycle of
    // each byte. bp_at >= 0 raises i_cell_bp when that byte is presented.
    task automatic send_bytes(input int len, input logic [3:0] pm, input logic [7:0] base,
                              input logic sof_first, input logic eof_last, input int bp_at);
        int w;
        for (int i = 0; i < len; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                in_valid   = 1'b1;
                in_data    = base + 8'(i);
                in_sof     = sof_first && (i == 0);
                in_eof     = eof_last && (i == len - 1);
                in_portmap = pm;
                if (i == bp_at) i_cell_bp = 1'b1;
                #1;
                w++;
            end while (!in_ready && w < 100);
            if (!in_ready) begin
                chk("send_timeout", 128'(i), 128'(len));
                break;
            end
            acc_c[i] = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    typedef struct {
        int           len;
        logic [3:0]   pm;
        logic [7:0]   base;
        int           exp_words;
        int           exp_ptrs;
        logic [15:0]  exp_desc;
        logic [127:0] exp_first;
        logic [127:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rdy_seen;
        int c0, c1, bi;

        vecs[0] = '{1,  4'b0010, 8'hA5, 1, 1, 16'h0201,
                    128'hA5000000000000000000000000000000, 128'hA5000000000000000000000000000000};
        vecs[1] = '{64, 4'b1001, 8'h00, 4, 1, 16'h0904,
                    128'h000102030405060708090A0B0C0D0E0F, 128'h303132333435363738393A3B3C3D3E3F};
        vecs[2] = '{5,  4'b0000, 8'h77, 0, 0, 16'h0000, 128'h0, 128'h0};
        vecs[3] = '{17, 4'b0100, 8'h10, 2, 1, 16'h0402,
                    128'h101112131415161718191A1B1C1D1E1F, 128'h20000000000000000000000000000000};
        vecs[4] = '{1,  4'b0000, 8'h33, 0, 0, 16'h0000, 128'h0, 128'h0};
        vecs[5] = '{16, 4'b1111, 8'hF0, 1, 1, 16'h0F01,
                    128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0; in_eof = 1'b0;
        in_portmap = '0; i_cell_bp = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data_wr", i_cell_data_fifo_wr, 0);
        chk("rst_data_din", i_cell_data_fifo_din, 0);
        chk("rst_ptr_wr", i_cell_ptr_fifo_wr, 0);
        chk("rst_ptr_din", i_cell_ptr_fifo_din, 0);
        chk_stats("rst");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            clear_q();
            send_bytes(vecs[v].len, vecs[v].pm, vecs[v].base, 1'b1, 1'b1, -1);
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_nwords", v), 128'(d_val.size()), 128'(vecs[v].exp_words));
            chk($sformatf("v%0d_nptrs", v), 128'(p_val.size()), 128'(vecs[v].exp_ptrs));
            if (vecs[v].exp_ptrs > 0 && p_val.size() > 0) begin
                chk($sformatf("v%0d_desc", v), p_val[0], vecs[v].exp_desc);
                chk($sformatf("v%0d_desc_cyc", v), 128'(p_cyc[0]), 128'(acc_c[vecs[v].len-1] + 1));
            end
            if (vecs[v].exp_words > 0 && d_val.size() == vecs[v].exp_words) begin
                chk($sformatf("v%0d_first", v), d_val[0], vecs[v].exp_first);
                chk($sformatf("v%0d_last", v), d_val[d_val.size()-1], vecs[v].exp_last);
                for (int k = 0; k < vecs[v].exp_words; k++) begin
                    bi = (16*k + 15 < vecs[v].len) ? 16*k + 15 : vecs[v].len - 1;
                    chk($sformatf("v%0d_w%0d_cyc", v, k), 128'(d_cyc[k]), 128'(acc_c[bi] + 1));
                end
            end
            exp_frames += vecs[v].exp_ptrs;
            if (vecs[v].pm == 4'd0) exp_drops++;
            chk_stats($sformatf("v%0d", v));
        end

        // Back-to-back single-byte frames: HOLD keeps in_ready low 2 cycles
        clear_q();
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = 8'h5A; in_portmap = 4'b0010;
        #1; chk("b2b_ready0", in_ready, 1); c0 = cyc;
        @(negedge clk); #1; chk("b2b_hold1", in_ready, 0);
        @(negedge clk); #1; chk("b2b_hold2", in_ready, 0);
        @(negedge clk); #1; chk("b2b_ready3", in_ready, 1); c1 = cyc;
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_sof_gap", 128'(c1 - c0), 3);
        chk("b2b_nptrs", 128'(p_val.size()), 2);
        if (p_val.size() == 2 && d_val.size() == 2) begin
            chk("b2b_ptr_gap", 128'(p_cyc[1] - p_cyc[0]), 3);
            chk("b2b_desc", p_val[1], 16'h0201);
            chk("b2b_word", d_val[1], 128'h5A000000000000000000000000000000);
        end
        exp_frames += 2;

        // Truncation: 2000 bytes, 96 words kept
        clear_q();
        send_bytes(2000, 4'b0011, 8'h00, 1'b1, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("trunc_nwords", 128'(d_val.size()), 96);
        chk("trunc_nptrs", 128'(p_val.size()), 1);
        if (p_val.size() == 1 && d_val.size() == 96) begin
            chk("trunc_desc", p_val[0], 16'h0360);
            chk("trunc_desc_cyc", 128'(p_cyc[0]), 128'(acc_c[1999] + 1));
            chk("trunc_lastw_cyc", 128'(d_cyc[95]), 128'(acc_c[1535] + 1));
        end
        exp_frames++; exp_trunc++;
        chk_stats("trunc");

        // Backpressure in IDLE holds off the sof; bp mid-frame is ignored
        clear_q();
        i_cell_bp = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b0; in_portmap = 4'b0001; in_data = 8'h40;
        rdy_seen = 0;
        repeat (4) begin
            #1; if (in_ready) rdy_seen++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("bp_idle_ready", 128'(rdy_seen), 0);
        chk("bp_idle_writes", 128'(d_val.size() + p_val.size()), 0);
        i_cell_bp = 1'b0;
        send_bytes(20, 4'b0001, 8'h40, 1'b1, 1'b1, 3);
        repeat (4) @(negedge clk);
        chk("bp_mid_nwords", 128'(d_val.size()), 2);
        chk("bp_mid_nptrs", 128'(p_val.size()), 1);
        if (p_val.size() == 1) chk("bp_mid_desc", p_val[0], 16'h0102);
        #1; chk("bp_after_ready", in_ready, 0);
        i_cell_bp = 1'b0;
        #1; chk("bp_release_ready", in_ready, 1);
        exp_frames++;
        chk_stats("bp");

        // Reset mid-frame: partial frame lost, no descriptor
        clear_q();
        send_bytes(20, 4'b0110, 8'h80, 1'b1, 1'b0, -1);
        #2; rstn = 1'b0; #1;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_data_wr", i_cell_data_fifo_wr, 0);
        chk("mrst_data_din", i_cell_data_fifo_din, 0);
        chk("mrst_ptr_wr", i_cell_ptr_fifo_wr, 0);
        chk("mrst_ptr_din", i_cell_ptr_fifo_din, 0);
        exp_frames = 0; exp_drops = 0; exp_trunc = 0;
        chk_stats("mrst");
        @(negedge clk); rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_nwords", 128'(d_val.size()), 1);
        chk("mrst_nptrs", 128'(p_val.size()), 0);

        // Without sof the bytes are discarded; then a fresh frame goes through
        clear_q();
        send_bytes(3, 4'b0110, 8'h90, 1'b0, 1'b1, -1);
        repeat (3) @(negedge clk);
        chk("nosof_writes", 128'(d_val.size() + p_val.size()), 0);
        send_bytes(1, 4'b0001, 8'hC3, 1'b1, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("fresh_nptrs", 128'(p_val.size()), 1);
        if (p_val.size() == 1 && d_val.size() == 1) begin
            chk("fresh_desc", p_val[0], 16'h0101);
            chk("fresh_word", d_val[0], 128'hC3000000000000000000000000000000);
        end
        exp_frames++;
        chk_stats("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
